traffic_intersection_ctrl: RTL
==============================

// Module: traffic_intersection_ctrl
// PURPOSE
//  Sequences a two-way intersection (main street / side street), each driven
//  as one traffic light using the 2-bit lamp state encoding
//  (green=00, yellow1=01, red=10, yellow2=11). Main street rests in green;
//  side-street vehicle and pedestrian requests are latched and served after a
//  minimum main green. Phase timing counts an external tick enable, so the
//  prescaler lives outside this block. Outputs feed the lamp decoders directly.
// PARAMETERS
//  T_MIN_GREEN  3  ticks main green must last before a pending request is served
//  T_SIDE_GREEN 5  ticks of side green
//  T_YELLOW     2  ticks of any yellow1 phase
//  T_PREP       1  ticks of yellow2 (red+yellow prep) before either green
//  CNT_W        8  phase counter width; every T_* must be in 1..2^CNT_W-1
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  tick        in   1      phase-time enable, one-cycle pulse
//  side_req    in   1      side-street vehicle sensor, level or pulse
//  ped_req     in   1      pedestrian button, level or pulse
//  main_state  out  2      main-street lamp state code
//  side_state  out  2      side-street lamp state code
//  walk        out  1      pedestrian walk lamp (crossing main street)
//  req_pending out  1      a latched request awaits service
// BEHAVIOUR
//  Clocking: one clock, async active-high rst; all state in clk domain.
//  Reset values: FSM=MAIN_GREEN, main_state=00, side_state=10, walk=0,
//   req_pending=0, counter=0, request latches=0.
//  FSM state -> (main_state, side_state):
//   MAIN_GREEN (00,10) -> MAIN_YELLOW (01,10) -> SIDE_PREP (10,11) ->
//   SIDE_GREEN (10,00) -> SIDE_YELLOW (10,01) -> MAIN_PREP (11,10) -> MAIN_GREEN.
//  The two streets are never both non-red. Outputs are registered and a
//   decode of the FSM state only.
//  Phase counter: cleared to 0 on the clock edge that enters a state.
//   Increments on tick and saturates at 2^CNT_W-1. A timed phase of length T
//   exits on the edge where tick=1 and cnt==T-1, so it lasts exactly T ticks.
//  MAIN_GREEN exit: tick=1, cnt>=T_MIN_GREEN-1 and req_pending=1.
//   With no request, main green holds indefinitely.
//  Timed exits: MAIN_YELLOW, SIDE_YELLOW use T_YELLOW; SIDE_PREP, MAIN_PREP use
//   T_PREP; SIDE_GREEN uses T_SIDE_GREEN.
//  Request latches: side_l, ped_l set on any cycle the input is high.
//   Exception: side_req is ignored while in SIDE_GREEN (already served).
//   req_pending = side_l | ped_l.
//  On entry to SIDE_GREEN: walk_l <= ped_l; side_l and ped_l are cleared.
//   If a request input is high on that same entry edge, it re-latches
//   (set wins over clear), except side_req, which is ignored per above.
//  walk = 1 only while in SIDE_GREEN with walk_l=1. walk drops on the edge
//   that leaves SIDE_GREEN; walk_l clears on that edge.
//  ped_req during SIDE_GREEN/SIDE_YELLOW/MAIN_PREP is latched and served next cycle.
//  tick with no pending exit condition only advances the counter.
//  rst mid-phase: immediate return to reset values, regardless of tick.
// TESTING
//  1 Reset, 20 ticks, no requests -> stays 00/10, walk=0, req_pending=0.
//  2 side_req pulse after tick 1 -> exits main green after tick 3; yellow 2 ticks,
//    prep 1, side green 5, side yellow 2, main prep 1; walk stays 0.
//  3 ped_req pulse at tick 10 of main green -> next tick exits main green;
//    walk=1 for exactly the 5 side-green ticks.
//  4 ped_req during SIDE_GREEN -> after MAIN_PREP, main green lasts exactly
//    3 ticks, then a second side cycle with walk=1.
//  5 Assert rst mid SIDE_GREEN with walk=1 -> same cycle 00/10, walk=0, latches clear.
//  6 Checker every cycle: never both states != 10; walk implies side_state==00.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection sequencer: main street rests in green, side-street
// vehicle and pedestrian requests are latched and served after a minimum
// main green. Phase timing counts an external tick enable.
module traffic_intersection_ctrl #(
    parameter int T_MIN_GREEN  = 3,
    parameter int T_SIDE_GREEN = 5,
    parameter int T_YELLOW     = 2,
    parameter int T_PREP       = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_state,
    output logic [1:0] side_state,
    output logic       walk,
    output logic       req_pending
);

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        SIDE_PREP,
        SIDE_GREEN,
        SIDE_YELLOW,
        MAIN_PREP
    } state_t;

    localparam logic [1:0] L_GREEN = 2'b00;
    localparam logic [1:0] L_YEL1  = 2'b01;
    localparam logic [1:0] L_RED   = 2'b10;
    localparam logic [1:0] L_YEL2  = 2'b11;

    // Last counter value of each phase; the exit happens on the tick seen there.
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] SIDE_G_LAST = CNT_W'(T_SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] PREP_LAST   = CNT_W'(T_PREP - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_l_q, side_l_d;
    logic             ped_l_q, ped_l_d;
    logic             walk_l_q, walk_l_d;
    logic [1:0]       main_q, main_d;
    logic [1:0]       side_q, side_d;
    logic             enter_side_green;
    logic             leave_side_green;

    assign req_pending = side_l_q | ped_l_q;
    assign main_state  = main_q;
    assign side_state  = side_q;
    // walk_l is only ever set while in SIDE_GREEN, so it is the walk lamp itself.
    assign walk        = walk_l_q;

    // Next-state logic: every transition is qualified by a tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN:  if (tick && cnt_q >= MIN_G_LAST && req_pending) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (tick && cnt_q == YEL_LAST)    state_d = SIDE_PREP;
            SIDE_PREP:   if (tick && cnt_q == PREP_LAST)   state_d = SIDE_GREEN;
            SIDE_GREEN:  if (tick && cnt_q == SIDE_G_LAST) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (tick && cnt_q == YEL_LAST)    state_d = MAIN_PREP;
            MAIN_PREP:   if (tick && cnt_q == PREP_LAST)   state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase
    end

    // Phase counter, request latches and lamp decode of the upcoming state.
    always_comb begin
        enter_side_green = (state_q != SIDE_GREEN) && (state_d == SIDE_GREEN);
        leave_side_green = (state_q == SIDE_GREEN) && (state_d != SIDE_GREEN);

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Serving the side phase consumes both requests; a fresh press on the
        // same edge wins over the clear. A vehicle already being served is ignored.
        side_l_d = side_l_q;
        ped_l_d  = ped_l_q;
        if (enter_side_green) begin
            side_l_d = 1'b0;
            ped_l_d  = 1'b0;
        end
        if (ped_req) begin
            ped_l_d = 1'b1;
        end
        if (side_req && state_q != SIDE_GREEN && state_d != SIDE_GREEN) begin
            side_l_d = 1'b1;
        end

        walk_l_d = walk_l_q;
        if (enter_side_green) begin
            walk_l_d = ped_l_q;
        end else if (leave_side_green) begin
            walk_l_d = 1'b0;
        end

        main_d = L_RED;
        side_d = L_RED;
        case (state_d)
            MAIN_GREEN:  main_d = L_GREEN;
            MAIN_YELLOW: main_d = L_YEL1;
            SIDE_PREP:   side_d = L_YEL2;
            SIDE_GREEN:  side_d = L_GREEN;
            SIDE_YELLOW: side_d = L_YEL1;
            MAIN_PREP:   main_d = L_YEL2;
            default: begin
                main_d = L_GREEN;
                side_d = L_RED;
            end
        endcase
    end

    // State, counter, latch and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MAIN_GREEN;
            cnt_q    <= '0;
            side_l_q <= 1'b0;
            ped_l_q  <= 1'b0;
            walk_l_q <= 1'b0;
            main_q   <= L_GREEN;
            side_q   <= L_RED;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            side_l_q <= side_l_d;
            ped_l_q  <= ped_l_d;
            walk_l_q <= walk_l_d;
            main_q   <= main_d;
            side_q   <= side_d;
        end
    end

endmodule
